// File: rtl/app_div_unit.sv
// app_div_unit: pipelined Mitchell (logarithmic) approximate divider.
// 16-bit dividend / divisor in, 32-bit Q16.16 quotient out.
// Register levels: S1 (leading-one detect at accept), S2 (log-domain
// subtract), S3 (antilog shift), then the result register driving the
// outputs, so an accept at edge N shows out_valid after edge N+3.
// Optional macro APP_DIV_CORR_EN subtracts CORR_FACTOR from a
// non-negative fraction difference to trim Mitchell's overestimate.
module app_div_unit #(
  parameter logic [14:0] CORR_FACTOR = 15'h0A00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic        div_zero
);

  // Position of the most significant set bit; 0 for a zero operand.
  function automatic logic [3:0] lead_one(input logic [15:0] x);
    lead_one = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (x[i]) lead_one = 4'(i);
    end
  endfunction

  // The 15 bits below the leading one, left-aligned.
  function automatic logic [14:0] frac_of(input logic [15:0] x, input logic [3:0] k);
    frac_of = 15'(x << (4'd15 - k));
  endfunction

  // Control state (reset).
  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  logic        s3_valid_q, s3_valid_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] quotient_q, quotient_d;
  logic        div_zero_q, div_zero_d;

  // Datapath state (no reset; qualified by the valid bits).
  logic        s1_sgn_q, s1_sgn_d, s1_neg_q, s1_neg_d;
  logic        s1_za_q, s1_za_d, s1_zb_q, s1_zb_d;
  logic [3:0]  s1_ka_q, s1_ka_d, s1_kb_q, s1_kb_d;
  logic [14:0] s1_fa_q, s1_fa_d, s1_fb_q, s1_fb_d;
  logic        s2_sgn_q, s2_sgn_d, s2_neg_q, s2_neg_d;
  logic        s2_za_q, s2_za_d, s2_zb_q, s2_zb_d;
  logic [15:0] s2_m_q, s2_m_d;
  logic [5:0]  s2_exp_q, s2_exp_d;
  logic        s3_sgn_q, s3_sgn_d, s3_neg_q, s3_neg_d;
  logic        s3_za_q, s3_za_d, s3_zb_q, s3_zb_d;
  logic [31:0] s3_mag_q, s3_mag_d;

  // Combinational intermediates.
  logic        adv;
  logic [15:0] a_abs, b_abs;
  logic [15:0] diff;
  logic [14:0] frac;
  logic [47:0] base, mag48;
  logic [5:0]  neg_exp;
  logic [31:0] result;

  // The whole pipe advances together whenever the output slot can move.
  assign in_ready  = !out_valid_q || out_ready;
  assign adv       = in_ready;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign div_zero  = div_zero_q;

  // Next-state logic for every stage; each register holds unless adv.
  always_comb begin
    // NOTE: every variable gets a default (its held value) before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    s3_valid_d  = s3_valid_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    div_zero_d  = div_zero_q;
    s1_sgn_d = s1_sgn_q; s1_neg_d = s1_neg_q; s1_za_d = s1_za_q; s1_zb_d = s1_zb_q;
    s1_ka_d  = s1_ka_q;  s1_kb_d  = s1_kb_q;  s1_fa_d = s1_fa_q; s1_fb_d = s1_fb_q;
    s2_sgn_d = s2_sgn_q; s2_neg_d = s2_neg_q; s2_za_d = s2_za_q; s2_zb_d = s2_zb_q;
    s2_m_d   = s2_m_q;   s2_exp_d = s2_exp_q;
    s3_sgn_d = s3_sgn_q; s3_neg_d = s3_neg_q; s3_za_d = s3_za_q; s3_zb_d = s3_zb_q;
    s3_mag_d = s3_mag_q;

    // S1: magnitudes, zero flags, characteristics and mantissa fractions.
    a_abs = (sign && dividend[15]) ? 16'(~dividend + 16'd1) : dividend;
    b_abs = (sign && divisor[15])  ? 16'(~divisor + 16'd1)  : divisor;

    // S2: log-domain subtraction; a negative fraction borrows one from e.
    diff = {1'b0, s1_fa_q} - {1'b0, s1_fb_q};
`ifdef APP_DIV_CORR_EN
    frac = diff[15] ? diff[14:0]
                    : ((diff[14:0] > CORR_FACTOR) ? (diff[14:0] - CORR_FACTOR) : 15'd0);
`else
    frac = diff[14:0];
`endif

    // S3: antilog as a shift of 1.16 mantissa inside a 48-bit field.
    base    = {31'd0, s2_m_q, 1'b0};
    neg_exp = 6'd0 - s2_exp_q;
    mag48   = s2_exp_q[5] ? (base >> neg_exp) : (base << s2_exp_q[4:0]);

    // Result register: special cases first, then signed saturation.
    if (s3_zb_q)       result = !s3_sgn_q ? 32'hFFFF_FFFF
                              : (s3_neg_q ? 32'h8000_0000 : 32'h7FFF_FFFF);
    else if (s3_za_q)  result = 32'd0;
    else if (!s3_sgn_q) result = s3_mag_q;
    else if (!s3_neg_q) result = s3_mag_q[31] ? 32'h7FFF_FFFF : s3_mag_q;
    else               result = s3_mag_q[31] ? 32'h8000_0000 : (~s3_mag_q + 32'd1);

    if (adv) begin
      s1_valid_d  = in_valid;
      s2_valid_d  = s1_valid_q;
      s3_valid_d  = s2_valid_q;
      out_valid_d = s3_valid_q;

      s1_sgn_d = sign;
      s1_neg_d = sign && (dividend[15] ^ divisor[15]);
      s1_za_d  = (a_abs == 16'd0);
      s1_zb_d  = (b_abs == 16'd0);
      s1_ka_d  = lead_one(a_abs);
      s1_kb_d  = lead_one(b_abs);
      s1_fa_d  = frac_of(a_abs, lead_one(a_abs));
      s1_fb_d  = frac_of(b_abs, lead_one(b_abs));

      s2_sgn_d = s1_sgn_q; s2_neg_d = s1_neg_q; s2_za_d = s1_za_q; s2_zb_d = s1_zb_q;
      s2_m_d   = {1'b1, frac};
      s2_exp_d = {2'b00, s1_ka_q} - {2'b00, s1_kb_q} - {5'd0, diff[15]};

      s3_sgn_d = s2_sgn_q; s3_neg_d = s2_neg_q; s3_za_d = s2_za_q; s3_zb_d = s2_zb_q;
      s3_mag_d = (|mag48[47:32]) ? 32'hFFFF_FFFF : mag48[31:0];

      if (s3_valid_q) begin
        quotient_d = result;
        div_zero_d = s3_zb_q;
      end
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= 32'd0;
      div_zero_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s3_valid_q  <= s3_valid_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      div_zero_q  <= div_zero_d;
    end
  end

  // Stage datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; their contents are ignored
    // until the matching valid bit (which is reset) marks them live.
    s1_sgn_q <= s1_sgn_d; s1_neg_q <= s1_neg_d; s1_za_q <= s1_za_d; s1_zb_q <= s1_zb_d;
    s1_ka_q  <= s1_ka_d;  s1_kb_q  <= s1_kb_d;  s1_fa_q <= s1_fa_d; s1_fb_q <= s1_fb_d;
    s2_sgn_q <= s2_sgn_d; s2_neg_q <= s2_neg_d; s2_za_q <= s2_za_d; s2_zb_q <= s2_zb_d;
    s2_m_q   <= s2_m_d;   s2_exp_q <= s2_exp_d;
    s3_sgn_q <= s3_sgn_d; s3_neg_q <= s3_neg_d; s3_za_q <= s3_za_d; s3_zb_q <= s3_zb_d;
    s3_mag_q <= s3_mag_d;
  end

endmodule

// File: doc/app_div_unit.md
Name: app_div_unit

Overview:
- Pipelined approximate logarithmic (Mitchell) divider. It is the inverse companion of the approximate multiplier in the core's approximate-arithmetic path.
- Takes 16-bit dividend and divisor and returns a 32-bit Q16.16 quotient.
- Steps: leading-one detect, subtract characteristics and fractions, antilog shift.
- Three-stage pipeline with valid/ready on both sides; sits between the vector-lane operand fetch and writeback.

Parameters:
- CORR_FACTOR, 15'h0A00, fractional correction constant (1.15 fraction LSBs); used only with APP_DIV_CORR_EN.

Ports:
- clk  in  1  core clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  unit can accept operands this cycle.
- sign  in  1  1 = operands are two's complement, 0 = unsigned.
- dividend  in  16  numerator.
- divisor  in  16  denominator.
- out_valid  out  1  quotient valid.
- out_ready  in  1  consumer accepts quotient.
- quotient  out  32  Q16.16 result (scalar_t).
- div_zero  out  1  divisor was zero; qualified by out_valid.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All stage valid bits, out_valid, quotient and div_zero go to 0. in_ready = 1 the cycle after reset deasserts.
  - In-flight operations are discarded; reset mid-stall drops everything.
- Handshake and stall:
  - Transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
  - in_ready = !out_valid || out_ready. When in_ready is 0, the whole pipeline stalls and all stage registers hold.
  - Latency is 3 cycles when not stalled: an accept at edge N gives out_valid after edge N+3.
  - Throughput is 1 per cycle. Bubbles propagate as invalid stages.
  - Outputs stay stable while out_valid && !out_ready.
- S1 (register at accept):
  - If sign: |a|=abs(dividend), |b|=abs(divisor) as 16-bit unsigned (abs(-32768)=0x8000); neg = dividend[15]^divisor[15].
  - Else: |a|=dividend, |b|=divisor, neg=0.
  - Flags: za = (|a|==0), zb = (|b|==0).
  - Leading-one positions k_a, k_b (0..15; 0 for a zero input).
  - Fractions f_a, f_b: 15 bits below the leading one, left-aligned, zero-filled.
- S2:
  - d = f_a - f_b (16-bit signed); e = k_a - k_b (signed 6-bit).
  - If d>=0: m = {1'b1, d[14:0]} (value 1+d), e' = e.
  - Else: m = {1'b1, d[14:0]} (value 2+d), e' = e-1. The range of e' is -16..15.
- S3:
  - Magnitude q = {m,1'b0} as 1.16 in a 48-bit field; shift left by e' if e'>=0, else right by -e'. Truncate (no rounding).
  - If magnitude ≥ 2^32: set to 0xFFFF_FFFF.
  - If sign: a positive result with magnitude > 0x7FFF_FFFF saturates to 0x7FFF_FFFF. A negative result is -magnitude, clamped at 0x8000_0000.
- Special cases:
  - zb: quotient = 0xFFFF_FFFF if !sign; 0x7FFF_FFFF (neg=0) or 0x8000_0000 (neg=1) if sign; div_zero=1.
  - za && !zb: quotient = 0, div_zero = 0.
  - zb takes priority over za.

Optional Feature:
- Macro APP_DIV_CORR_EN.
- Defined: in S2, when d>=0, fraction = max(d - CORR_FACTOR, 0) before forming m. The d<0 path is unchanged.
- Undefined: no correction logic is generated and CORR_FACTOR is unused.

Test Plan:
- Unsigned 100/10 -> quotient 0x000A_8000 (10.5), div_zero=0; with APP_DIV_CORR_EN: 0x0009_E000.
- Unsigned 64/128 (exact powers of two) -> 0x0000_8000. Unsigned 5/7 (d<0 path) -> 0x0000_C000, unaffected by APP_DIV_CORR_EN.
- Signed -30/5 -> 0xFFF9_8000 (-6.5); with APP_DIV_CORR_EN: 0xFFF9_D000.
- Divide by zero:
  - Unsigned 7/0 -> 0xFFFF_FFFF, div_zero=1.
  - Signed -5/0 -> 0x8000_0000, div_zero=1.
  - 0/0 -> div_zero=1.
  - 0/9 -> 0x0000_0000, div_zero=0.
- Signed saturation: -32768/-1 -> 0x7FFF_FFFF.
- Back-to-back and back-pressure: 5 ops on consecutive cycles with out_ready=0 for 4 cycles after first out_valid. Required:
  - in_ready drops while stalled.
  - Outputs hold.
  - All 5 results emerge in order with no loss or duplication.
  - Asserting reset during the stall clears out_valid next cycle and no stale result appears.
